gpio_in_sync_irq: RTL and testbench
===================================

// Module: gpio_in_sync_irq
// PURPOSE
//   Input-side stage directly downstream of the GPIO pad interface (io_if).
//   Consumes raw in_pad_i and gpio_eclk from the pads and synchronises both to pclk.
//   Optionally re-samples selected bits on an external-clock edge.
//   Produces the registered input value (RGPIO_IN) and per-bit sticky interrupt
//   status with a single irq line for the APB register block.
// PARAMETERS
//   DW           32  number of GPIO lines
//   SYNC_STAGES  2   synchroniser depth on in_pad_i and gpio_eclk; legal values are >=2
// PORTS
//   pclk       in   1   system clock; all logic on its rising edge
//   preset     in   1   synchronous, active-high reset
//   in_pad_i   in   DW  raw pad inputs from io_if; asynchronous to pclk
//   gpio_eclk  in   1   external sampling clock from io_if; asynchronous to pclk
//   eclk_sel   in   DW  per bit: 1 = sample on the gpio_eclk edge, 0 = track every pclk
//   nec        in   1   1 = use the falling edge of gpio_eclk, 0 = use the rising edge
//   inte       in   DW  per-bit interrupt enable
//   ptrig      in   DW  per-bit polarity: 1 = rising edge / high level, 0 = falling edge / low level
//   ctype      in   DW  per-bit type: 1 = edge-triggered, 0 = level-triggered
//   gie        in   1   global interrupt enable
//   ints_clr   in   DW  write-1-to-clear strobe for ints, one pclk wide
//   rgpio_in   out  DW  synchronised, sampled input value
//   ints       out  DW  sticky interrupt status
//   irq        out  1   registered interrupt request
// BEHAVIOUR
//   Reset
//     - While preset=1: every flop is cleared, including sync chains, eclk history,
//       prev, and the fill counter.
//     - rgpio_in=0, ints=0, irq=0.
//   Synchronisers
//     - in_pad_i passes through a SYNC_STAGES flop chain to give s_in.
//     - gpio_eclk passes through its own SYNC_STAGES chain plus one history flop.
//     - ecl_ev = (s_eclk & ~h) when nec=0, or (~s_eclk & h) when nec=1.
//     - ecl_ev is a single-cycle pulse per external edge.
//   Sampling (registered)
//     - Bits with eclk_sel=0: rgpio_in[i] <= s_in[i] every cycle.
//     - Bits with eclk_sel=1: rgpio_in[i] <= s_in[i] only when ecl_ev=1; otherwise hold.
//   Latency
//     - Pad change to rgpio_in is SYNC_STAGES+1 pclk cycles (3 by default) for
//       eclk_sel=0 bits.
//     - Changing eclk_sel takes effect on the next cycle; rgpio_in does not glitch.
//   Event detect
//     - prev <= rgpio_in every cycle.
//     - Edge event (ctype=1): rise = rgpio_in & ~prev; fall = ~rgpio_in & prev.
//       ev = ptrig ? rise : fall.
//     - Level event (ctype=0): ev = (rgpio_in == ptrig); it re-asserts every cycle
//       while the level holds.
//   Fill guard
//     - A saturating counter runs from 0 to SYNC_STAGES+1 after reset.
//     - ev is masked until the counter saturates, so no spurious edge comes from
//       the reset value of 0.
//   Status update (per bit)
//     - ints[i] <= (ints[i] & ~ints_clr[i]) | (inte[i] & ev[i]).
//     - If set and clear hit the same cycle, set wins and the bit stays 1.
//     - inte=0 blocks new sets but does not clear bits already set.
//   irq
//     - irq <= gie & |ints, one cycle after ints. ints keeps updating when gie=0.
//   Reset mid-operation
//     - Everything clears and the fill guard re-arms.
//     - Status pending before reset is lost.
// TESTING
//   1. Reset, eclk_sel=0, in_pad_i=32'hABCD_1234 -> rgpio_in=32'hABCD_1234 three
//      cycles later; ints=0 (fill guard; inte=0).
//   2. inte=ptrig=ctype=bit0, gie=1, pad bit0 0->1 -> ints=32'h1 at cycle 4 and
//      irq=1 at cycle 5; ints_clr=1 -> ints=0, then irq=0 the following cycle.
//   3. Level-low on bit31 (ctype=0, ptrig=0, inte=bit31), pad low -> ints_clr
//      pulse is ignored (set wins), ints[31] stays 1 until the pad goes high and
//      is then cleared.
//   4. eclk_sel=32'hFFFF_FFFF, nec=0, pad=32'hDEAD_BEAD, no gpio_eclk edge ->
//      rgpio_in holds its old value; one gpio_eclk rising edge -> rgpio_in =
//      32'hDEAD_BEAD; nec=1 with a rising-only edge gives no update.
//   5. Pads at 32'hFFFF_FFFF during and after reset, edge/rising enabled on all
//      bits -> ints stays 0.
//   6. Assert preset mid-pending (ints=32'hA5A5_9C9C) -> ints=0 and irq=0 the
//      next cycle.

Source files
------------

// File: rtl/gpio_in_sync_irq.sv
// ---------------------------------------------------------------------------
// gpio_in_sync_irq
//
// Input stage that sits directly after the GPIO pad interface. It brings the
// raw pad inputs and the external sampling clock into the pclk domain. It can
// re-sample selected bits on an external-clock edge. It produces the
// registered input value and a per-bit sticky interrupt status, and it ORs
// that status into a single interrupt request for the APB register block.
//
// Parameters
//   DW           number of GPIO lines
//   SYNC_STAGES  synchroniser depth on in_pad_i and gpio_eclk (>= 2)
//
// Ports
//   pclk       in   1   system clock, rising edge
//   preset     in   1   synchronous active-high reset
//   in_pad_i   in   DW  raw pad inputs (asynchronous to pclk)
//   gpio_eclk  in   1   external sampling clock (asynchronous to pclk)
//   eclk_sel   in   DW  1 = sample on the gpio_eclk edge, 0 = track every pclk
//   nec        in   1   1 = falling edge of gpio_eclk, 0 = rising edge
//   inte       in   DW  per-bit interrupt enable
//   ptrig      in   DW  1 = rising edge / high level, 0 = falling edge / low level
//   ctype      in   DW  1 = edge-triggered, 0 = level-triggered
//   gie        in   1   global interrupt enable
//   ints_clr   in   DW  write-1-to-clear strobe for ints
//   rgpio_in   out  DW  synchronised, sampled input value
//   ints       out  DW  sticky interrupt status
//   irq        out  1   registered interrupt request
// ---------------------------------------------------------------------------
module gpio_in_sync_irq #(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic [DW-1:0] in_pad_i,
    input  logic          gpio_eclk,
    input  logic [DW-1:0] eclk_sel,
    input  logic          nec,
    input  logic [DW-1:0] inte,
    input  logic [DW-1:0] ptrig,
    input  logic [DW-1:0] ctype,
    input  logic          gie,
    input  logic [DW-1:0] ints_clr,
    output logic [DW-1:0] rgpio_in,
    output logic [DW-1:0] ints,
    output logic          irq
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_depth
        $error("gpio_in_sync_irq: SYNC_STAGES must be at least 2");
    end

    localparam int              CW       = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0]   FILL_MAX = CW'(SYNC_STAGES + 1);

    // -----------------------------------------------------------------------
    // Synchronisers
    // -----------------------------------------------------------------------
    logic [DW-1:0]          sync_in [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_eclk;
    logic                   eclk_hist;
    logic [DW-1:0]          s_in;
    logic                   s_eclk;
    logic                   ecl_ev;

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_in[k] <= '0;
            end
        end else begin
            sync_in[0] <= in_pad_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_in[k] <= sync_in[k-1];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            sync_eclk <= '0;
            eclk_hist <= 1'b0;
        end else begin
            sync_eclk <= {sync_eclk[SYNC_STAGES-2:0], gpio_eclk};
            eclk_hist <= s_eclk;
        end
    end

    assign s_in   = sync_in[SYNC_STAGES-1];
    assign s_eclk = sync_eclk[SYNC_STAGES-1];

    // One pclk-wide pulse per selected external-clock edge.
    assign ecl_ev = nec ? (~s_eclk & eclk_hist) : (s_eclk & ~eclk_hist);

    // -----------------------------------------------------------------------
    // Sampling register
    // -----------------------------------------------------------------------
    logic [DW-1:0] sample_en;

    // A per-bit enable mux means a change of eclk_sel only decides whether
    // the next edge loads or holds, so the output never sees a partial value.
    assign sample_en = ~eclk_sel | {DW{ecl_ev}};

    always_ff @(posedge pclk) begin
        if (preset) begin
            rgpio_in <= '0;
        end else begin
            rgpio_in <= (sample_en & s_in) | (~sample_en & rgpio_in);
        end
    end

    // -----------------------------------------------------------------------
    // Fill guard
    // -----------------------------------------------------------------------
    // The counter reaches FILL_MAX on the same edge that the first
    // post-reset pad sample lands in rgpio_in. At that point prev still holds
    // its reset zero. The guard therefore opens one cycle later, once prev
    // also holds a real sample. This prevents pads already high at reset from
    // being seen as an edge.
    logic [CW-1:0] fill_cnt;
    logic          fill_done;

    always_ff @(posedge pclk) begin
        if (preset) begin
            fill_cnt  <= '0;
            fill_done <= 1'b0;
        end else begin
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            fill_done <= (fill_cnt == FILL_MAX);
        end
    end

    // -----------------------------------------------------------------------
    // Event detect
    // -----------------------------------------------------------------------
    logic [DW-1:0] prev;
    logic [DW-1:0] rise;
    logic [DW-1:0] fall;
    logic [DW-1:0] edge_ev;
    logic [DW-1:0] lvl_ev;
    logic [DW-1:0] ev;

    always_ff @(posedge pclk) begin
        if (preset) begin
            prev <= '0;
        end else begin
            prev <= rgpio_in;
        end
    end

    assign rise    = rgpio_in & ~prev;
    assign fall    = ~rgpio_in & prev;
    assign edge_ev = (ptrig & rise) | (~ptrig & fall);
    assign lvl_ev  = ~(rgpio_in ^ ptrig);
    assign ev      = ((ctype & edge_ev) | (~ctype & lvl_ev)) & {DW{fill_done}};

    // -----------------------------------------------------------------------
    // Sticky status and interrupt request
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            ints <= '0;
        end else begin
            // A new set takes priority over a clear in the same cycle.
            ints <= (ints & ~ints_clr) | (inte & ev);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            irq <= 1'b0;
        end else begin
            irq <= gie & (|ints);
        end
    end

endmodule

// File: tb/tb_gpio_in_sync_irq.sv
module tb_gpio_in_sync_irq;

    localparam int DW = 32;
    localparam int S  = 2;

    logic          pclk = 1'b0;
    logic          preset;
    logic [DW-1:0] in_pad_i;
    logic          gpio_eclk;
    logic [DW-1:0] eclk_sel;
    logic          nec;
    logic [DW-1:0] inte;
    logic [DW-1:0] ptrig;
    logic [DW-1:0] ctype;
    logic          gie;
    logic [DW-1:0] ints_clr;
    logic [DW-1:0] rgpio_in;
    logic [DW-1:0] ints;
    logic          irq;

    gpio_in_sync_irq #(.DW(DW), .SYNC_STAGES(S)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .in_pad_i  (in_pad_i),
        .gpio_eclk (gpio_eclk),
        .eclk_sel  (eclk_sel),
        .nec       (nec),
        .inte      (inte),
        .ptrig     (ptrig),
        .ctype     (ctype),
        .gie       (gie),
        .ints_clr  (ints_clr),
        .rgpio_in  (rgpio_in),
        .ints      (ints),
        .irq       (irq)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [DW-1:0] rg;
        logic [DW-1:0] st;
        logic          rq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void cmp(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model. The synchroniser is treated as a plain delay line of
    // sampled pad/eclk values (reset edges contribute zero). The guard opens
    // once prev holds a genuinely sampled pad value.
    logic [DW-1:0] pad_hist[$];
    logic          eclk_hist[$];
    logic [DW-1:0] m_rg, m_prev, m_ints;
    logic          m_irq;
    int            m_edges;

    task automatic model_clear();
        pad_hist  = {};
        eclk_hist = {};
        for (int k = 0; k < S; k++)  pad_hist.push_back('0);
        for (int k = 0; k <= S; k++) eclk_hist.push_back(1'b0);
        m_rg = '0; m_prev = '0; m_ints = '0; m_irq = 1'b0; m_edges = 0;
    endtask

    task automatic model_step();
        logic [DW-1:0] s_in, new_rg, new_ints;
        logic          s_e, h, tick, ev;
        exp_t          e;
        if (preset) begin
            model_clear();
        end else begin
            s_in = pad_hist[S-1];
            s_e  = eclk_hist[S-1];
            h    = eclk_hist[S];
            tick = nec ? (!s_e && h) : (s_e && !h);
            for (int b = 0; b < DW; b++) begin
                new_rg[b] = (eclk_sel[b] && !tick) ? m_rg[b] : s_in[b];
                if (ctype[b])
                    ev = ptrig[b] ? (m_rg[b] && !m_prev[b]) : (!m_rg[b] && m_prev[b]);
                else
                    ev = (m_rg[b] == ptrig[b]);
                if (m_edges < S + 2) ev = 1'b0;
                new_ints[b] = (inte[b] && ev) ? 1'b1 : (m_ints[b] && !ints_clr[b]);
            end
            m_irq  = gie && (m_ints != 0);
            m_prev = m_rg;
            m_rg   = new_rg;
            m_ints = new_ints;
            m_edges++;
            pad_hist.push_front(in_pad_i);
            void'(pad_hist.pop_back());
            eclk_hist.push_front(gpio_eclk);
            void'(eclk_hist.pop_back());
        end
        e.rg = m_rg; e.st = m_ints; e.rq = m_irq;
        exp_q.push_back(e);
    endtask

    // Inputs are set right after a negedge. The model then predicts the
    // state after the coming posedge.
    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge pclk);
        end
    endtask

    // Monitor
    always @(posedge pclk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("rgpio_in", rgpio_in, e.rg);
            cmp("ints", ints, e.st);
            cmp("irq", {31'b0, irq}, {31'b0, e.rq});
        end
    end

    initial begin
        preset = 1'b1; in_pad_i = 32'hABCD_1234; gpio_eclk = 1'b0; eclk_sel = '0;
        nec = 1'b0; inte = '0; ptrig = '0; ctype = '0; gie = 1'b0; ints_clr = '0;
        model_clear();
        @(negedge pclk);

        // 1: reset, then pad value appears three cycles later
        step(3);
        cmp("reset_rgpio", rgpio_in, '0);
        cmp("reset_ints", ints, '0);
        cmp("reset_irq", {31'b0, irq}, '0);
        preset = 1'b0;
        step(3);
        cmp("t1_rgpio", rgpio_in, 32'hABCD_1234);
        step(3);
        cmp("t1_ints", ints, '0);

        // 2: rising edge on bit0
        inte = 32'h1; ptrig = 32'h1; ctype = 32'h1; gie = 1'b1; in_pad_i = '0;
        step(6);
        in_pad_i = 32'h1;
        step(4);
        cmp("t2_ints_set", ints, 32'h1);
        step(1);
        cmp("t2_irq_set", {31'b0, irq}, 32'h1);
        ints_clr = 32'h1;
        step(1);
        ints_clr = '0;
        cmp("t2_ints_clr", ints, '0);
        step(1);
        cmp("t2_irq_clr", {31'b0, irq}, '0);

        // 3: level-low on bit31, clear ignored while level holds
        inte = 32'h8000_0000; ctype = '0; ptrig = '0; in_pad_i = '0;
        step(5);
        ints_clr = 32'h8000_0000;
        step(1);
        ints_clr = '0;
        step(1);
        cmp("t3_set_wins", ints & 32'h8000_0000, 32'h8000_0000);
        in_pad_i = 32'h8000_0000;
        step(5);
        ints_clr = 32'h8000_0000;
        step(1);
        ints_clr = '0;
        cmp("t3_cleared", ints, '0);

        // 4: external-clock sampling
        inte = '0; eclk_sel = '1; nec = 1'b0; in_pad_i = 32'hDEAD_BEAD;
        step(6);
        cmp("t4_hold", rgpio_in, 32'h8000_0000);
        gpio_eclk = 1'b1;
        step(5);
        cmp("t4_rise", rgpio_in, 32'hDEAD_BEAD);
        gpio_eclk = 1'b0;
        step(5);
        nec = 1'b1; in_pad_i = 32'h1234_5678;
        step(3);
        gpio_eclk = 1'b1;
        step(5);
        cmp("t4_nec_norise", rgpio_in, 32'hDEAD_BEAD);

        // 5: pads high through reset, no spurious edge
        eclk_sel = '0; nec = 1'b0; gpio_eclk = 1'b0; in_pad_i = '1;
        preset = 1'b1;
        step(3);
        inte = '1; ptrig = '1; ctype = '1; gie = 1'b1; preset = 1'b0;
        step(10);
        cmp("t5_ints", ints, '0);
        cmp("t5_irq", {31'b0, irq}, '0);

        // 6: reset while status pending
        ctype = '0; ptrig = '0; inte = 32'hA5A5_9C9C; in_pad_i = '0;
        step(6);
        cmp("t6_pending", ints, 32'hA5A5_9C9C);
        preset = 1'b1;
        step(1);
        preset = 1'b0;
        cmp("t6_ints", ints, '0);
        cmp("t6_irq", {31'b0, irq}, '0);

        // Randomised run
        for (int c = 0; c < 3000; c++) begin
            if (c % 97 == 0) begin
                eclk_sel = $urandom; inte = $urandom; ptrig = $urandom;
                ctype = $urandom; gie = $urandom_range(0, 1); nec = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 2) == 0) in_pad_i = in_pad_i ^ $urandom;
            if ($urandom_range(0, 3) == 0) gpio_eclk = ~gpio_eclk;
            ints_clr = ($urandom_range(0, 3) == 0) ? $urandom : '0;
            preset   = ($urandom_range(0, 199) == 0);
            step(1);
        end
        preset = 1'b0; ints_clr = '0;
        step(2);

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        if (n_cmp < 100) begin
            n_bad++;
            $display("FAIL coverage: got %0d compares expected >= 100", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
